// File: rtl/sirius_exc_pkg.sv
// rtl/sirius_exc_pkg.sv - shared exception codes, cm_exc bit map, vectors and request types
package sirius_exc_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam int EXC_W          = 10;
  localparam int BIT_ADEL_IF    = 0;
  localparam int BIT_TLBL_IF_RF = 1;
  localparam int BIT_TLBL_IF_IV = 2;
  localparam int BIT_RI         = 3;
  localparam int BIT_SYS        = 4;
  localparam int BIT_BP         = 5;
  localparam int BIT_OV         = 6;
  localparam int BIT_ADEL_MEM   = 7;
  localparam int BIT_ADES_MEM   = 8;
  localparam int BIT_TLB_MEM    = 9;

  localparam logic [31:0] EXC_VECTOR_DEF    = 32'hBFC0_0380;
  localparam logic [31:0] REFILL_VECTOR_DEF = 32'hBFC0_0200;

  typedef enum logic [1:0] {BVA_NONE, BVA_PC, BVA_MEM} bva_sel_t;

  typedef struct packed {
    logic      hit;
    exc_code_t code;
    bva_sel_t  bva_sel;
    logic      refill;
    logic      is_eret;
  } exc_req_t;

  // Request as captured when leaving IDLE; refill already qualified by EXL.
  typedef struct packed {
    logic [4:0]  code;
    logic        is_eret;
    logic        bva_en;
    logic [31:0] bva;
    logic [31:0] epc;
    logic        bd;
    logic        refill;
  } pend_t;

endpackage

// File: rtl/exc_prioritizer.sv
// rtl/exc_prioritizer.sv - picks the winning exception/interrupt/ERET of the committing instruction
module exc_prioritizer
  import sirius_exc_pkg::*;
(
  input  logic [EXC_W-1:0] exc,
  input  logic             irq,
  input  logic             eret,
  input  logic             tlb_store,
  input  logic             tlb_mod,
  input  logic             tlb_refill,
  output exc_req_t         req
);

  always_comb begin
    req.hit     = irq | (|exc) | eret;
    req.code    = EXC_INT;
    req.bva_sel = BVA_NONE;
    req.refill  = 1'b0;
    req.is_eret = 1'b0;
    if (irq) begin
      req.code = EXC_INT;
    end else if (exc[BIT_ADEL_IF]) begin
      req.code    = EXC_ADEL;
      req.bva_sel = BVA_PC;
    end else if (exc[BIT_TLBL_IF_RF] | exc[BIT_TLBL_IF_IV]) begin
      req.code    = EXC_TLBL;
      req.bva_sel = BVA_PC;
      req.refill  = exc[BIT_TLBL_IF_RF];
    end else if (exc[BIT_RI]) begin
      req.code = EXC_RI;
    end else if (exc[BIT_SYS]) begin
      req.code = EXC_SYS;
    end else if (exc[BIT_BP]) begin
      req.code = EXC_BP;
    end else if (exc[BIT_OV]) begin
      req.code = EXC_OV;
    end else if (exc[BIT_ADEL_MEM]) begin
      req.code    = EXC_ADEL;
      req.bva_sel = BVA_MEM;
    end else if (exc[BIT_ADES_MEM]) begin
      req.code    = EXC_ADES;
      req.bva_sel = BVA_MEM;
    end else if (exc[BIT_TLB_MEM]) begin
      req.bva_sel = BVA_MEM;
      if (tlb_mod) begin
        req.code = EXC_MOD;
      end else if (tlb_store) begin
        req.code   = EXC_TLBS;
        req.refill = tlb_refill;
      end else begin
        req.code   = EXC_TLBL;
        req.refill = tlb_refill;
      end
    end else if (eret) begin
      req.is_eret = 1'b1;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - commit-stage exception controller driving COP0 updates and pipeline redirect
module exception_ctrl
  import sirius_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
  parameter logic [31:0] REFILL_VECTOR = REFILL_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic [9:0]  cm_exc,
  input  logic        cm_tlb_store,
  input  logic        cm_tlb_mod,
  input  logic        cm_tlb_refill,
  input  logic        cm_eret,
  input  logic [31:0] cm_mem_vaddr,
  input  logic        mem_busy,
  input  logic        cp0_exl,
  input  logic [31:0] epc_address,
  input  logic        allow_interrupt,
  input  logic [7:0]  interrupt_flag,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic        exp_bd,
  output logic        exl_clean,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_badvaddr,
  output logic [31:0] exp_epc,
  output logic        commit_stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FIRE} state_t;

  state_t   state, state_n;
  exc_req_t req;
  pend_t    live, pend_q, src;
  logic     irq, take, fire_n;
  logic [4:0] last_code;
  logic       last_bd;

  assign irq  = allow_interrupt & (|interrupt_flag);
  assign take = cm_valid & req.hit;

  exc_prioritizer u_prio (
    .exc        (cm_exc),
    .irq        (irq),
    .eret       (cm_eret),
    .tlb_store  (cm_tlb_store),
    .tlb_mod    (cm_tlb_mod),
    .tlb_refill (cm_tlb_refill),
    .req        (req)
  );

  always_comb begin
    live.code    = req.code;
    live.is_eret = req.is_eret;
    live.bva_en  = (req.bva_sel != BVA_NONE);
    live.bva     = (req.bva_sel == BVA_PC)  ? cm_pc :
                   (req.bva_sel == BVA_MEM) ? cm_mem_vaddr : 32'd0;
    live.epc     = cm_bd ? (cm_pc - 32'd4) : cm_pc;
    live.bd      = cm_bd;
    live.refill  = req.refill & ~cp0_exl;
  end

  // Straight from IDLE the live request fires; after DRAIN only the latched copy counts.
  assign src = (state == ST_IDLE) ? live : pend_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    commit_stall = (state != ST_IDLE) | take;
    case (state)
      ST_IDLE:  if (take) state_n = mem_busy ? ST_DRAIN : ST_FIRE;
      ST_DRAIN: if (!mem_busy) state_n = ST_FIRE;
      ST_FIRE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign fire_n = (state_n == ST_FIRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q          <= '0;
      last_code       <= 5'd0;
      last_bd         <= 1'b0;
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_bd          <= 1'b0;
      exl_clean       <= 1'b0;
      exp_code        <= 5'd0;
      exp_badvaddr    <= 32'd0;
      exp_epc         <= 32'd0;
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
    end else begin
      if (state == ST_IDLE && take) pend_q <= live;
      exp_en          <= fire_n;
      flush           <= fire_n;
      redirect_valid  <= fire_n;
      exp_badvaddr_en <= 1'b0;
      exp_bd          <= 1'b0;
      exl_clean       <= 1'b0;
      exp_code        <= 5'd0;
      exp_badvaddr    <= 32'd0;
      exp_epc         <= 32'd0;
      redirect_pc     <= 32'd0;
      if (fire_n) begin
        if (src.is_eret) begin
          // Cause fields are replayed so COP0 sees them unchanged.
          exl_clean   <= 1'b1;
          exp_code    <= last_code;
          exp_bd      <= last_bd;
          exp_epc     <= epc_address;
          redirect_pc <= epc_address;
        end else begin
          exp_code        <= src.code;
          exp_bd          <= src.bd;
          exp_epc         <= src.epc;
          exp_badvaddr_en <= src.bva_en;
          exp_badvaddr    <= src.bva;
          redirect_pc     <= src.refill ? REFILL_VECTOR : EXC_VECTOR;
          last_code       <= src.code;
          last_bd         <= src.bd;
        end
      end
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed vector bench for exception_ctrl
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cm_valid, cm_bd, cm_tlb_store, cm_tlb_mod, cm_tlb_refill, cm_eret;
  logic [31:0] cm_pc, cm_mem_vaddr, epc_address;
  logic [9:0]  cm_exc;
  logic        mem_busy, cp0_exl, allow_interrupt;
  logic [7:0]  interrupt_flag;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, commit_stall, flush, redirect_valid;
  logic [4:0]  exp_code;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_bd(cm_bd), .cm_exc(cm_exc),
    .cm_tlb_store(cm_tlb_store), .cm_tlb_mod(cm_tlb_mod), .cm_tlb_refill(cm_tlb_refill),
    .cm_eret(cm_eret), .cm_mem_vaddr(cm_mem_vaddr), .mem_busy(mem_busy), .cp0_exl(cp0_exl),
    .epc_address(epc_address), .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag),
    .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_bd(exp_bd), .exl_clean(exl_clean),
    .exp_code(exp_code), .exp_badvaddr(exp_badvaddr), .exp_epc(exp_epc),
    .commit_stall(commit_stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  typedef struct {
    string       name;
    logic [9:0]  exc;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        st, md, rf, allow;
    logic [7:0]  flag;
    logic        exl;
    logic [4:0]  code;
    logic        bva_en;
    logic [31:0] bva;
    logic [31:0] epc;
    logic        ebd;
    logic [31:0] redir;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cm_valid = 0; cm_bd = 0; cm_pc = 0; cm_exc = 0; cm_tlb_store = 0; cm_tlb_mod = 0;
    cm_tlb_refill = 0; cm_eret = 0; cm_mem_vaddr = 0; mem_busy = 0; cp0_exl = 0;
    epc_address = 0; allow_interrupt = 0; interrupt_flag = 0;
  endtask

  task automatic drive(input vec_t v);
    cm_valid = 1; cm_exc = v.exc; cm_bd = v.bd; cm_pc = v.pc; cm_mem_vaddr = v.vaddr;
    cm_tlb_store = v.st; cm_tlb_mod = v.md; cm_tlb_refill = v.rf; cm_eret = 0;
    allow_interrupt = v.allow; interrupt_flag = v.flag; cp0_exl = v.exl;
  endtask

  task automatic check_fire(input vec_t v);
    chk({v.name, ".exp_en"}, {31'd0, exp_en}, 32'd1);
    chk({v.name, ".flush"}, {31'd0, flush}, 32'd1);
    chk({v.name, ".redirect_valid"}, {31'd0, redirect_valid}, 32'd1);
    chk({v.name, ".exl_clean"}, {31'd0, exl_clean}, 32'd0);
    chk({v.name, ".code"}, {27'd0, exp_code}, {27'd0, v.code});
    chk({v.name, ".bva_en"}, {31'd0, exp_badvaddr_en}, {31'd0, v.bva_en});
    if (v.bva_en) chk({v.name, ".bva"}, exp_badvaddr, v.bva);
    chk({v.name, ".epc"}, exp_epc, v.epc);
    chk({v.name, ".bd"}, {31'd0, exp_bd}, {31'd0, v.ebd});
    chk({v.name, ".redirect"}, redirect_pc, v.redir);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #1 chk({v.name, ".stall"}, {31'd0, commit_stall}, 32'd1);
    @(posedge clk); #1;
    check_fire(v);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk({v.name, ".one_cycle"}, {31'd0, exp_en | flush | redirect_valid}, 32'd0);
  endtask

  initial begin
    vec_t s;
    vt[0]  = '{"sys",       10'h010, 0, 32'h8000_0100, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd8,  0, 32'h0,         32'h8000_0100, 0, 32'hBFC0_0380};
    vt[1]  = '{"ov_bd",     10'h040, 1, 32'h8000_0204, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd12, 0, 32'h0,         32'h8000_0200, 1, 32'hBFC0_0380};
    vt[2]  = '{"irq_ri",    10'h008, 0, 32'h8000_0300, 32'h0,         0,0,0, 1, 8'h04, 0, 5'd0,  0, 32'h0,         32'h8000_0300, 0, 32'hBFC0_0380};
    vt[3]  = '{"tlb_rf",    10'h200, 0, 32'h8000_0400, 32'h0040_0010, 0,0,1, 0, 8'h00, 0, 5'd2,  1, 32'h0040_0010, 32'h8000_0400, 0, 32'hBFC0_0200};
    vt[4]  = '{"tlb_rf_exl",10'h200, 0, 32'h8000_0400, 32'h0040_0010, 0,0,1, 0, 8'h00, 1, 5'd2,  1, 32'h0040_0010, 32'h8000_0400, 0, 32'hBFC0_0380};
    vt[5]  = '{"adel_if",   10'h041, 0, 32'h8000_0001, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd4,  1, 32'h8000_0001, 32'h8000_0001, 0, 32'hBFC0_0380};
    vt[6]  = '{"tlbl_if",   10'h002, 0, 32'h0050_0000, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd2,  1, 32'h0050_0000, 32'h0050_0000, 0, 32'hBFC0_0200};
    vt[7]  = '{"tlb_mod",   10'h200, 0, 32'h8000_0500, 32'h0060_0004, 1,1,0, 0, 8'h00, 0, 5'd1,  1, 32'h0060_0004, 32'h8000_0500, 0, 32'hBFC0_0380};
    vt[8]  = '{"tlbs",      10'h200, 0, 32'h8000_0504, 32'h0060_0008, 1,0,0, 0, 8'h00, 0, 5'd3,  1, 32'h0060_0008, 32'h8000_0504, 0, 32'hBFC0_0380};
    vt[9]  = '{"adel_ades", 10'h180, 0, 32'h8000_0600, 32'h0070_0002, 0,0,0, 0, 8'h00, 0, 5'd4,  1, 32'h0070_0002, 32'h8000_0600, 0, 32'hBFC0_0380};
    vt[10] = '{"bp_ov",     10'h060, 0, 32'h8000_0700, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd9,  0, 32'h0,         32'h8000_0700, 0, 32'hBFC0_0380};
    vt[11] = '{"epc_wrap",  10'h010, 1, 32'h0000_0002, 32'h0,         0,0,0, 0, 8'h00, 0, 5'd8,  0, 32'h0,         32'hFFFF_FFFE, 1, 32'hBFC0_0380};
    vt[12] = '{"irq_mask",  10'h008, 0, 32'h8000_0800, 32'h0,         0,0,0, 0, 8'hFF, 0, 5'd10, 0, 32'h0,         32'h8000_0800, 0, 32'hBFC0_0380};

    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.exp_en", {31'd0, exp_en}, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk("rst.exp_code", {27'd0, exp_code}, 32'd0);
    chk("rst.stall", {31'd0, commit_stall}, 32'd0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 13; i++) apply(vt[i]);

    // AdES held behind a 3-cycle bus drain; inputs change meanwhile and must be ignored
    @(negedge clk);
    cm_valid = 1; cm_exc = 10'h100; cm_pc = 32'h8000_0900; cm_mem_vaddr = 32'h1000_0003; mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      cm_exc = 10'h010; cm_mem_vaddr = 32'hDEAD_BEEF; allow_interrupt = 1; interrupt_flag = 8'hFF;
      if (c == 2) mem_busy = 0;
      #1 chk("drain.stall", {31'd0, commit_stall}, 32'd1);
      chk("drain.no_en", {31'd0, exp_en}, 32'd0);
    end
    @(posedge clk); #1;
    s = '{"ades_drain", 10'h100, 0, 32'h8000_0900, 32'h1000_0003, 0,0,0, 0, 8'h00, 0, 5'd5, 1, 32'h1000_0003, 32'h8000_0900, 0, 32'hBFC0_0380};
    check_fire(s);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk("drain.done_en", {31'd0, exp_en}, 32'd0);
    chk("drain.done_stall", {31'd0, commit_stall}, 32'd0);

    // Sys in a delay slot, then ERET replays code 8 / bd 1
    s = '{"sys_bd", 10'h010, 1, 32'h8000_0104, 32'h0, 0,0,0, 0, 8'h00, 0, 5'd8, 0, 32'h0, 32'h8000_0100, 1, 32'hBFC0_0380};
    apply(s);
    @(negedge clk);
    cm_valid = 1; cm_eret = 1; cm_pc = 32'h8000_0200; epc_address = 32'h8000_0104;
    @(posedge clk); #1;
    chk("eret.exp_en", {31'd0, exp_en}, 32'd1);
    chk("eret.exl_clean", {31'd0, exl_clean}, 32'd1);
    chk("eret.code", {27'd0, exp_code}, 32'd8);
    chk("eret.bd", {31'd0, exp_bd}, 32'd1);
    chk("eret.epc", exp_epc, 32'h8000_0104);
    chk("eret.bva_en", {31'd0, exp_badvaddr_en}, 32'd0);
    chk("eret.redirect", redirect_pc, 32'h8000_0104);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);

    // Reset during DRAIN must abort without a strobe
    @(negedge clk);
    cm_valid = 1; cm_exc = 10'h010; cm_pc = 32'h8000_0A00; mem_busy = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 1; cm_valid = 0; cm_exc = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0; mem_busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_drain.no_en", {31'd0, exp_en | flush}, 32'd0);
      chk("rst_drain.stall", {31'd0, commit_stall}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
